// File: rtl/s_pea_out_collector.sv
// Streaming output collector: takes one word per fresh PE result, buffers it in a small
// first-word-fall-through FIFO and re-emits it on a valid/ready stream with frame-last tagging.
module s_pea_out_collector #(
   parameter int N_BITS = 32,
   parameter int DEPTH  = 4,
   parameter int LEN_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic [N_BITS-1:0] pe_res_i,
   input  logic              pe_valid_i,
   output logic              pea_ready_o,
   output logic [N_BITS-1:0] m_data_o,
   output logic              m_valid_o,
   output logic              m_last_o,
   input  logic              m_ready_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              ovf_o
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int LW1 = LEN_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  recv_cnt_q, recv_cnt_d;
   logic              rdy_q;
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q, count_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;
   logic [N_BITS:0]   mem_q [DEPTH];

   logic              accept, push, pop, full, empty, last_tag, ready;
   logic [LW1-1:0]    recv_next;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign accept    = (state_q == S_RUN) && pe_valid_i && rdy_q;
   assign pop       = !empty && m_ready_i;
   assign push      = accept && (!full || pop);
   assign last_tag  = (recv_cnt_q == len_q - LEN_W'(1));
   assign recv_next = {1'b0, recv_cnt_q} + LW1'(accept);

   // One slot of margin covers the word the PE latches on the same edge ready is seen.
   assign ready = (state_q == S_RUN) && (count_q < CW'(DEPTH - 1))
                  && (recv_next < {1'b0, len_q});

   assign pea_ready_o = ready;
   assign m_valid_o   = !empty;
   assign m_data_o    = empty ? '0 : mem_q[rd_ptr_q][N_BITS-1:0];
   assign m_last_o    = empty ? 1'b0 : mem_q[rd_ptr_q][N_BITS];
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = done_q;
   assign ovf_o       = ovf_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d    = state_q;
      len_d      = len_q;
      recv_cnt_d = recv_cnt_q;
      done_d     = 1'b0;
      ovf_d      = ovf_q | (accept && full && !pop);
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (len_i != '0) begin
                  len_d      = len_i;
                  recv_cnt_d = '0;
                  state_d    = S_RUN;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (accept) begin
               recv_cnt_d = recv_next[LEN_W-1:0];
               if (recv_next == {1'b0, len_q}) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (empty) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         recv_cnt_q <= '0;
         rdy_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         recv_cnt_q <= recv_cnt_d;
         rdy_q      <= ready;
         count_q    <= count_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   // NOTE: storage is not reset; the empty count already masks stale entries on the outputs.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= {last_tag, pe_res_i};
   end

endmodule

// File: tb/tb_s_pea_out_collector.sv
// Bench for s_pea_out_collector: a ready-driven PE model feeds the collector and a
// scoreboard of expected {last, data} words is checked against every output pop.
module tb_s_pea_out_collector;

   localparam int N_BITS = 32;
   localparam int LEN_W  = 16;

   typedef struct packed {
      logic              last;
      logic [N_BITS-1:0] data;
   } exp_t;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              start_i;
   logic [LEN_W-1:0]  len_i;
   logic [N_BITS-1:0] pe_res_i;
   logic              pe_valid_i;
   logic              pea_ready_o;
   logic [N_BITS-1:0] m_data_o;
   logic              m_valid_o;
   logic              m_last_o;
   logic              m_ready_i;
   logic              busy_o;
   logic              done_o;
   logic              ovf_o;

   s_pea_out_collector #(.N_BITS(N_BITS), .DEPTH(4), .LEN_W(LEN_W)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .len_i       (len_i),
      .pe_res_i    (pe_res_i),
      .pe_valid_i  (pe_valid_i),
      .pea_ready_o (pea_ready_o),
      .m_data_o    (m_data_o),
      .m_valid_o   (m_valid_o),
      .m_last_o    (m_last_o),
      .m_ready_i   (m_ready_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .ovf_o       (ovf_o)
   );

   always #5 clk_i = ~clk_i;

   int   n_total = 0;
   int   n_bad   = 0;
   exp_t exp_q[$];

   int   vals[16];
   int   n_vals;
   int   pe_idx;
   int   frame_len;
   bit   pe_active;

   int   cyc = 0;
   int   done_cnt = 0;
   int   done_cyc = 0;
   int   last_pop_cyc = 0;
   int   ready_seen = 0;
   logic busy_last = 1'b0;
   logic busy_at_done = 1'b0;
   logic busy_before_done = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic pe_load(input int base, input int n, input int flen);
      for (int i = 0; i < n; i++) vals[i] = base + i;
      n_vals     = n;
      pe_idx     = 0;
      frame_len  = flen;
      pe_active  = 1'b1;
      pe_valid_i = 1'b0;
      pe_res_i   = '0;
   endtask

   // PE output register: refreshes only after an edge where ready was high.
   task automatic pe_advance();
      exp_t e;
      if (pe_idx < n_vals) begin
         pe_res_i   = N_BITS'(vals[pe_idx]);
         pe_valid_i = 1'b1;
         e.last     = (pe_idx == frame_len - 1);
         e.data     = N_BITS'(vals[pe_idx]);
         exp_q.push_back(e);
         pe_idx++;
      end else begin
         pe_valid_i = 1'b0;
      end
   endtask

   // One clock: sample just before the edge, then step to the next falling edge.
   task automatic tick();
      logic pr;
      exp_t e;
      #1;
      pr = pea_ready_o;
      if (pr) ready_seen++;
      if (done_o) begin
         done_cnt++;
         done_cyc         = cyc;
         busy_at_done     = busy_o;
         busy_before_done = busy_last;
      end
      if (m_valid_o && m_ready_i) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pop", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            check("pop_data", m_data_o, e.data);
            check("pop_last", m_last_o, e.last);
         end
         last_pop_cyc = cyc;
      end
      busy_last = busy_o;
      @(posedge clk_i);
      @(negedge clk_i);
      cyc++;
      if (pr && pe_active) pe_advance();
   endtask

   task automatic start_frame(input int len);
      len_i   = LEN_W'(len);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) tick();
      check({tag, "_done"}, done_cnt - d0, 1);
      check({tag, "_busy_at_done"}, busy_at_done, 0);
      check({tag, "_busy_before_done"}, busy_before_done, 1);
      tick();
      check({tag, "_done_single"}, done_cnt - d0, 1);
      check({tag, "_sb_empty"}, exp_q.size(), 0);
   endtask

   task automatic do_reset();
      pe_active  = 1'b0;
      pe_valid_i = 1'b0;
      rst_i      = 1'b1;
      tick();
      rst_i      = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int r0;
      rst_i      = 1'b1;
      start_i    = 1'b0;
      len_i      = '0;
      pe_res_i   = '0;
      pe_valid_i = 1'b0;
      m_ready_i  = 1'b0;
      pe_active  = 1'b0;
      n_vals     = 0;
      pe_idx     = 0;
      frame_len  = 0;
      @(negedge clk_i);
      tick(); tick(); tick();
      rst_i = 1'b0;
      tick();
      check("rst_m_valid", m_valid_o, 0);
      check("rst_pea_ready", pea_ready_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_ovf", ovf_o, 0);

      // Basic frame of three words with the sink always ready.
      pe_load(32'hA, 3, 3);
      m_ready_i = 1'b1;
      start_frame(3);
      check("t1_busy", busy_o, 1);
      wait_done("t1", 40);
      check("t1_done_latency", done_cyc - last_pop_cyc, 2);
      check("t1_pe_words", pe_idx, 3);

      // Stalled sink: PE holds a stale valid word, no duplicate may be captured.
      pe_load(1, 10, 10);
      m_ready_i = 1'b0;
      start_frame(10);
      for (int i = 0; i < 20; i++) tick();
      check("t2_pea_ready_stall", pea_ready_o, 0);
      check("t2_ovf", ovf_o, 0);
      check("t2_pe_words", pe_idx, 4);
      check("t2_m_valid", m_valid_o, 1);
      check("t2_head", m_data_o, 1);
      check("t2_sb_depth", exp_q.size(), 4);
      m_ready_i = 1'b1;
      wait_done("t2", 80);
      check("t2_pe_all", pe_idx, 10);
      check("t2_ovf_end", ovf_o, 0);

      // Full FIFO: push+pop keeps order, push without pop overflows.
      pe_load(32'h31, 8, 100);
      m_ready_i = 1'b0;
      start_frame(100);
      for (int i = 0; i < 12; i++) tick();
      check("t3_pe_words", pe_idx, 4);
      check("t3_pea_ready_full", pea_ready_o, 0);
      pe_active  = 1'b0;
      pe_res_i   = 32'hF00D;
      pe_valid_i = 1'b1;
      m_ready_i  = 1'b1;
      exp_q.push_back(exp_t'{last: 1'b0, data: 32'hF00D});
      force dut.accept = 1'b1;
      tick();
      release dut.accept;
      m_ready_i = 1'b0;
      check("t3_ovf_pushpop", ovf_o, 0);
      check("t3_head_after", m_data_o, 32'h32);
      check("t3_still_full", pea_ready_o, 0);
      pe_res_i = 32'hDEAD;
      force dut.accept = 1'b1;
      tick();
      release dut.accept;
      pe_valid_i = 1'b0;
      check("t3_ovf_set", ovf_o, 1);
      tick(); tick(); tick();
      check("t3_ovf_sticky", ovf_o, 1);
      m_ready_i = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check("t3_sb_empty", exp_q.size(), 0);
      check("t3_ovf_hold", ovf_o, 1);
      do_reset();
      check("t3_ovf_cleared", ovf_o, 0);
      check("t3_busy_reset", busy_o, 0);

      // Zero-length frame.
      r0 = ready_seen;
      d0 = done_cnt;
      start_frame(0);
      check("t4_done", done_o, 1);
      check("t4_busy", busy_o, 0);
      tick();
      check("t4_done_pulse", done_cnt - d0, 1);
      check("t4_done_low", done_o, 0);
      tick();
      check("t4_no_ready", ready_seen - r0, 0);
      check("t4_busy_after", busy_o, 0);

      // Reset in the middle of a frame with two words buffered.
      pe_load(32'h51, 8, 8);
      m_ready_i = 1'b0;
      start_frame(8);
      for (int i = 0; i < 20 && pe_idx < 3; i++) tick();
      check("t5_pe_words", pe_idx, 3);
      check("t5_m_valid_pre", m_valid_o, 1);
      d0 = done_cnt;
      do_reset();
      check("t5_m_valid", m_valid_o, 0);
      check("t5_pea_ready", pea_ready_o, 0);
      check("t5_busy", busy_o, 0);
      check("t5_done", done_o, 0);
      exp_q.delete();
      tick(); tick();
      check("t5_no_done", done_cnt - d0, 0);
      pe_load(32'h77, 1, 1);
      m_ready_i = 1'b1;
      start_frame(1);
      wait_done("t5_new", 30);

      // start_i during RUN with a different length is ignored.
      pe_load(32'h61, 7, 3);
      m_ready_i = 1'b1;
      start_frame(3);
      tick();
      len_i   = LEN_W'(7);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      wait_done("t6", 40);
      check("t6_pe_words", pe_idx, 3);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
